// File: rtl/rsfq_merge_sync.sv
// rsfq_merge_sync
//   Cycle-based model of an RSFQ merger (confluence buffer). Two toggle-encoded
//   pulse inputs are merged into one toggle-encoded output. Every edge on a line
//   is one SFQ pulse. Detected pulses are buffered (up to DEPTH) and released
//   no closer than MIN_SPACING cycles apart. Input pulses are discarded for
//   BEGIN_CYCLES cycles after reset.
//
//   Parameters: MIN_SPACING >= 1, DEPTH >= 1.
//
// Ports
//   clk_i       clock, all state updates on the rising edge
//   rst_i       synchronous, active-high reset
//   a_i, b_i    toggle-encoded pulse inputs
//   q_o         toggle-encoded merged output
//   pending_o   buffered pulses not yet emitted
//   overflow_o  sticky: at least one pulse was dropped on saturation
//   ready_o     high once the startup window has elapsed
module rsfq_merge_sync #(
  parameter int unsigned BEGIN_CYCLES     = 8,
  parameter int unsigned MIN_SPACING      = 2,
  parameter int unsigned DEPTH            = 4,
  parameter bit          MERGE_COINCIDENT = 1'b1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         a_i,
  input  logic                         b_i,
  output logic                         q_o,
  output logic [$clog2(DEPTH+1)-1:0]   pending_o,
  output logic                         overflow_o,
  output logic                         ready_o
);

  localparam int PW  = $clog2(DEPTH + 1);
  localparam int PW1 = PW + 1;
  localparam int SW  = (BEGIN_CYCLES > 0) ? $clog2(BEGIN_CYCLES + 1) : 1;
  localparam int CW  = (MIN_SPACING > 1) ? $clog2(MIN_SPACING) : 1;

  localparam logic [SW-1:0]  START_LOAD = SW'(BEGIN_CYCLES);
  localparam logic [SW-1:0]  START_ONE  = SW'(1);
  localparam logic [CW-1:0]  COOL_LOAD  = CW'(MIN_SPACING - 1);
  localparam logic [CW-1:0]  COOL_ONE   = CW'(1);
  localparam logic [PW1-1:0] DEPTH_W    = PW1'(DEPTH);
  localparam logic [PW-1:0]  DEPTH_P    = PW'(DEPTH);

  logic [SW-1:0] start_q, start_d;
  logic          ready_q, ready_d;
  logic [CW-1:0] cool_q, cool_d;
  logic [PW-1:0] pend_q, pend_d;
  logic          a_q, b_q;
  logic          q_q, q_d;
  logic          ovf_q, ovf_d;

  logic          pa, pb, emit;
  logic [1:0]    arrivals;
  logic [PW1-1:0] pend_sum;

  always_comb begin
    pa = a_i ^ a_q;
    pb = b_i ^ b_q;

    // Detections are only accepted once the startup window has closed; the
    // edge that closes it still discards.
    arrivals = 2'd0;
    if (ready_q) begin
      if (MERGE_COINCIDENT && pa && pb) begin
        arrivals = 2'd1;
      end else begin
        arrivals = {1'b0, pa} + {1'b0, pb};
      end
    end

    emit = ready_q && (pend_q != '0) && (cool_q == '0);

    start_d = start_q;
    ready_d = ready_q;
    if (start_q != '0) begin
      start_d = start_q - START_ONE;
      ready_d = (start_q == START_ONE);
    end else begin
      ready_d = 1'b1;
    end

    q_d    = q_q ^ emit;
    cool_d = cool_q;
    if (emit) begin
      cool_d = COOL_LOAD;
    end else if (cool_q != '0) begin
      cool_d = cool_q - COOL_ONE;
    end

    // One bit wider so a saturating arrival is visible before clamping.
    // A simultaneous emit and arrival nets out, so a full buffer loses nothing.
    pend_sum = {1'b0, pend_q} + PW1'(arrivals) - PW1'(emit);
    ovf_d    = ovf_q;
    if (pend_sum > DEPTH_W) begin
      pend_d = DEPTH_P;
      ovf_d  = 1'b1;
    end else begin
      pend_d = pend_sum[PW-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    // History follows the inputs even in reset so release creates no pulse.
    a_q <= a_i;
    b_q <= b_i;
    if (rst_i) begin
      start_q <= START_LOAD;
      ready_q <= 1'b0;
      cool_q  <= '0;
      pend_q  <= '0;
      q_q     <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      start_q <= start_d;
      ready_q <= ready_d;
      cool_q  <= cool_d;
      pend_q  <= pend_d;
      q_q     <= q_d;
      ovf_q   <= ovf_d;
    end
  end

  assign q_o        = q_q;
  assign pending_o  = pend_q;
  assign overflow_o = ovf_q;
  assign ready_o    = ready_q;

endmodule

// File: doc/rsfq_merge_sync.md
Name: rsfq_merge_sync

Overview:
- Cycle-based synchronous model of an RSFQ merger (confluence buffer), the inverse of the splitter: two pulse inputs feed one pulse output.
- Pulses are toggle-encoded, as in the rest of the cell library: every edge on a line (rising or falling) is one SFQ pulse.
- Used in clocked co-simulation and FPGA emulation of RSFQ netlists.
- Adds pulse buffering, minimum output spacing, coincidence merging and a startup blanking window.

Parameters:
- BEGIN_CYCLES, 8, cycles after reset during which input pulses are discarded (startup window).
- MIN_SPACING, 2, minimum cycles between output pulses; must be >= 1.
- DEPTH, 4, maximum buffered pending pulses; must be >= 1.
- MERGE_COINCIDENT, 1, 1 = pulses on a and b detected in the same cycle merge into one output pulse; 0 = both are counted.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- a  input  1  toggle-encoded pulse input 0.
- b  input  1  toggle-encoded pulse input 1.
- q  output  1  toggle-encoded merged pulse output.
- pending  output  $clog2(DEPTH+1)  count of buffered, not-yet-emitted pulses.
- overflow  output  1  sticky flag: at least one pulse dropped due to saturation.
- ready  output  1  high once the startup window has elapsed (operational state 0).

Behaviour:
- Reset (rst=1 at a clk edge):
  - q=0, pending=0, overflow=0, ready=0, cooldown=0.
  - startup counter loads BEGIN_CYCLES.
  - history regs a_d<=a, b_d<=b, so no spurious pulse is detected on release.
- Pulse detection, every non-reset edge including during startup:
  - pa = a ^ a_d, pb = b ^ b_d.
  - then a_d<=a, b_d<=b.
- Startup:
  - while the startup counter is nonzero, it decrements, ready=0, and pa/pb are discarded.
  - the edge at which it reaches 0 sets ready=1; detections count from the next edge on.
- Arrivals n:
  - n = pa + pb (0..2).
  - if MERGE_COINCIDENT=1 and pa & pb, then n = 1.
- Emission, evaluated on registered values at the edge:
  - emit = ready & (pending > 0) & (cooldown == 0).
  - on emit: q <= ~q, cooldown <= MIN_SPACING-1.
  - otherwise cooldown decrements if nonzero.
- Latency: a pulse detected at edge k increments pending at edge k; the earliest q toggle is edge k+1.
- Pending update:
  - next = pending + n - emit, computed one bit wider than pending.
  - if next > DEPTH: pending <= DEPTH and overflow <= 1. Excess pulses are lost; overflow stays set until reset.
  - a simultaneous emit and arrival nets correctly; no loss when pending=DEPTH, emit=1, n=1.
- Reset mid-operation: all buffered pulses are discarded, outputs return to reset values, and the startup window restarts.
  - if q was 1, it drops to 0. Downstream must be reset in the same cycle, or it sees one pulse.
- No other states. Internal state is only: startup counter, cooldown, pending, a_d, b_d, q, overflow.

Test Plan:
- Startup blanking: rst high 1 cycle, then toggle a at edge 3 after release.
  - required: q stays 0, pending 0.
  - required: ready rises at edge 8 after release.
  - required: a further a toggle at edge 10 gives q=1 at edge 11.
- Single pulse: after ready, toggle a once at edge k.
  - required: pending=1 after edge k; q toggles 0->1 at edge k+1; pending=0 after k+1.
  - required: overflow stays 0.
- Coincidence: toggle a and b in the same cycle at edge k.
  - MERGE_COINCIDENT=1: exactly one q toggle at k+1.
  - MERGE_COINCIDENT=0: q toggles at k+1 and k+3 (MIN_SPACING=2), pending peaks at 2.
- Saturation: DEPTH=2, MIN_SPACING=2; toggle a on 6 consecutive edges 1..6.
  - required pending sequence: 1,1,2,2,2(sat),2.
  - required: overflow=1 from edge 5.
  - required: exactly 5 total q toggles, then pending returns to 0.
- Full-buffer net: DEPTH=1, MIN_SPACING=1; toggle a every cycle.
  - required: pending holds at 1, q toggles every cycle, overflow stays 0.
- Reset mid-burst: pending=3, q=1, overflow=1, then rst for 1 cycle.
  - required: next edge shows q=0, pending=0, overflow=0, ready=0.
  - required: input toggles during the following 8 cycles produce no output.
